// File: rtl/dac_spi_tx_pkg.sv
// Shared audio-path definitions: SPI frame geometry, FSM state encoding and
// small constant helpers used by the DAC serial output stage.
package synth_pkg;

  // Serial transmitter states, in the order a frame walks through them
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  localparam int FRAME_W   = 24;
  localparam int DAC_CMD_W = 8;
  localparam int DATA_W    = FRAME_W - DAC_CMD_W;

  localparam logic [DAC_CMD_W-1:0] DEFAULT_DAC_CMD = 8'h00;

  // Bits needed for a counter that runs 0..maxVal (never less than one bit)
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

  // cs_n-low duration of one frame: setup + 24 full SCLK periods + hold
  function automatic int frameCycles(input int halfPeriod);
    return (2 * FRAME_W + 2) * halfPeriod;
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample-in / SPI-out bundle of the DAC serial stage. The master side is
// whoever feeds samples and watches the DAC pins; the slave side is the
// transmitter itself.
interface dac_spi_tx_if;
  import synth_pkg::*;

  logic              i_enable;
  logic [DATA_W-1:0] i_data;
  logic              o_dac_sclk;
  logic              o_dac_mosi;
  logic              o_dac_cs_n;
  logic              o_sample_ack;
  logic              o_busy;
  logic              o_overrun;

  modport master (
    output i_enable,
    output i_data,
    input  o_dac_sclk,
    input  o_dac_mosi,
    input  o_dac_cs_n,
    input  o_sample_ack,
    input  o_busy,
    input  o_overrun
  );

  modport slave (
    input  i_enable,
    input  i_data,
    output o_dac_sclk,
    output o_dac_mosi,
    output o_dac_cs_n,
    output o_sample_ack,
    output o_busy,
    output o_overrun
  );

endinterface

// File: rtl/dac_spi_tx_sample_tick.sv
// Free-running sample-rate tick: one-cycle pulse every DIV clocks while
// enabled. Shared by any stage that needs an audio-rate strobe.
module sample_tick #(
  parameter int DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_tick
);
  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_atMax;

  assign w_atMax = (r_count == CNT_MAX);

  // Count 0..DIV-1 and wrap; park at zero whenever the stage is disabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (!i_enable || w_atMax) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Gated so a disable arriving on the wrap cycle cannot launch a frame
  assign o_tick = i_enable && w_atMax;

endmodule

// File: rtl/dac_spi_tx.sv
// DAC serial output stage: once per sample tick, latches the 16-bit sample
// and ships {DAC_CMD, sample} as a 24-bit SPI mode-0 frame, MSB first.
// Ticks that land while a frame is still in flight are dropped and flagged
// on the sticky overrun output.
module dac_spi_tx
  import synth_pkg::*;
#(
  parameter int                   CLK_DIV    = 2,
  parameter int                   SAMPLE_DIV = 1000,
  parameter logic [DAC_CMD_W-1:0] DAC_CMD    = DEFAULT_DAC_CMD
) (
  input logic         i_clk,
  input logic         i_rst,
  dac_spi_tx_if.slave bus
);
  localparam int              HC_W    = cntWidth(CLK_DIV - 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(CLK_DIV - 1);
  localparam int              BC_W    = cntWidth(FRAME_W - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);

  spi_state_t         r_state;
  spi_state_t         w_stateNext;
  logic [HC_W-1:0]    r_halfCnt;
  logic [HC_W-1:0]    w_halfCntNext;
  logic [BC_W-1:0]    r_bitCnt;
  logic [BC_W-1:0]    w_bitCntNext;
  logic [FRAME_W-1:0] r_shiftReg;
  logic [FRAME_W-1:0] w_shiftRegNext;
  logic               r_sclk;
  logic               w_sclkNext;
  logic               r_mosi;
  logic               w_mosiNext;
  logic               r_csN;
  logic               w_csNNext;
  logic               r_ack;
  logic               w_ackNext;
  logic               r_busy;
  logic               w_busyNext;
  logic               r_overrun;
  logic               w_overrunNext;

  logic               w_tick;
  logic               w_halfDone;
  logic [FRAME_W-1:0] w_frameLoad;

  sample_tick #(
    .DIV (SAMPLE_DIV)
  ) u_sampleTick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (bus.i_enable),
    .o_tick   (w_tick)
  );

  assign w_halfDone  = (r_halfCnt == HC_MAX);
  assign w_frameLoad = {DAC_CMD, bus.i_data};

  // State, counters, shift register and every output pin are registered here
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_halfCnt  <= '0;
      r_bitCnt   <= '0;
      r_shiftReg <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_csN      <= 1'b1;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_halfCnt  <= w_halfCntNext;
      r_bitCnt   <= w_bitCntNext;
      r_shiftReg <= w_shiftRegNext;
      r_sclk     <= w_sclkNext;
      r_mosi     <= w_mosiNext;
      r_csN      <= w_csNNext;
      r_ack      <= w_ackNext;
      r_busy     <= w_busyNext;
      r_overrun  <= w_overrunNext;
    end
  end

  // Frame sequencing: half-period timing, bit shifting and pin values
  always_comb begin
    w_stateNext    = r_state;
    w_halfCntNext  = r_halfCnt;
    w_bitCntNext   = r_bitCnt;
    w_shiftRegNext = r_shiftReg;
    w_sclkNext     = r_sclk;
    w_mosiNext     = r_mosi;
    w_csNNext      = r_csN;
    w_ackNext      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_stateNext    = ST_SETUP;
          w_shiftRegNext = w_frameLoad;
          w_mosiNext     = w_frameLoad[FRAME_W-1];
          w_bitCntNext   = BC_LAST;
          w_halfCntNext  = '0;
          w_csNNext      = 1'b0;
          w_ackNext      = 1'b1;
        end
      end

      ST_SETUP: begin
        if (w_halfDone) begin
          w_stateNext   = ST_SHIFT;
          w_sclkNext    = 1'b1;
          w_halfCntNext = '0;
        end else begin
          w_halfCntNext = r_halfCnt + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (!w_halfDone) begin
          w_halfCntNext = r_halfCnt + 1'b1;
        end else begin
          w_halfCntNext = '0;
          if (r_sclk) begin
            w_sclkNext     = 1'b0;
            w_shiftRegNext = {r_shiftReg[FRAME_W-2:0], 1'b0};
            w_mosiNext     = (r_bitCnt == '0) ? 1'b0 : r_shiftReg[FRAME_W-2];
          end else if (r_bitCnt == '0) begin
            w_stateNext = ST_HOLD;
          end else begin
            w_bitCntNext = r_bitCnt - 1'b1;
            w_sclkNext   = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (w_halfDone) begin
          w_stateNext   = ST_IDLE;
          w_halfCntNext = '0;
          w_csNNext     = 1'b1;
        end else begin
          w_halfCntNext = r_halfCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_csNNext   = 1'b1;
        w_sclkNext  = 1'b0;
        w_mosiNext  = 1'b0;
      end
    endcase
  end

  // Busy mirrors the next state so it stays aligned with cs_n
  always_comb begin
    w_busyNext = (w_stateNext != ST_IDLE);
  end

  // Sticky overrun: set by any tick outside IDLE, cleared only by disabling
  always_comb begin
    w_overrunNext = r_overrun;
    if (!bus.i_enable) begin
      w_overrunNext = 1'b0;
    end else if (w_tick && (r_state != ST_IDLE)) begin
      w_overrunNext = 1'b1;
    end
  end

  assign bus.o_dac_sclk   = r_sclk;
  assign bus.o_dac_mosi   = r_mosi;
  assign bus.o_dac_cs_n   = r_csN;
  assign bus.o_sample_ack = r_ack;
  assign bus.o_busy       = r_busy;
  assign bus.o_overrun    = r_overrun;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for the DAC serial stage: two instances (200- and 80-cycle sample
// periods), a pin-level SPI monitor that rebuilds frames, and a scoreboard of
// expected frames filled as samples are presented.
module tb_dac_spi_tx;
  import synth_pkg::*;

  localparam int H         = 2;
  localparam int SD0       = 200;
  localparam int SD1       = 80;
  localparam logic [7:0] CMD0 = 8'h00;
  localparam logic [7:0] CMD1 = 8'h5A;
  localparam int FRAME_LEN = frameCycles(H);

  localparam int W_STARTS  = 0;
  localparam int W_DONES   = 1;
  localparam int W_RISES   = 2;
  localparam int W_OVERRUN = 3;

  typedef struct {
    logic [23:0] data;
    int          rises;
    int          len;
    int          riseOff;
    bit          ack;
    int          fallCyc;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  int nChecks = 0;
  int nPass   = 0;

  logic [23:0] expQ0[$];
  logic [23:0] expQ1[$];
  frame_t      gotQ0[$];
  frame_t      gotQ1[$];

  logic        prevCs[2]      = '{1'b1, 1'b1};
  logic        prevSclk[2]    = '{1'b0, 1'b0};
  logic [23:0] shiftCap[2];
  int          curRises[2]    = '{0, 0};
  int          fallAt[2]      = '{0, 0};
  int          firstRiseAt[2] = '{0, 0};
  bit          ackFall[2];
  int          starts[2]      = '{0, 0};
  int          dones[2]       = '{0, 0};
  int          strayAck[2]    = '{0, 0};
  int          idleErr[2]     = '{0, 0};
  int          busyErr[2]     = '{0, 0};
  logic [5:0]  monS;
  frame_t      monRec;

  dac_spi_tx_if if0 ();
  dac_spi_tx_if if1 ();

  dac_spi_tx #(.CLK_DIV(H), .SAMPLE_DIV(SD0), .DAC_CMD(CMD0)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if0.slave)
  );

  dac_spi_tx #(.CLK_DIV(H), .SAMPLE_DIV(SD1), .DAC_CMD(CMD1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if1.slave)
  );

  // 10-time-unit clock and a cycle index that advances on every rising edge
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Pins of one instance packed as {cs_n, sclk, mosi, ack, busy, overrun}
  function automatic logic [5:0] sig(input int id);
    if (id == 0)
      return {if0.o_dac_cs_n, if0.o_dac_sclk, if0.o_dac_mosi,
              if0.o_sample_ack, if0.o_busy, if0.o_overrun};
    return {if1.o_dac_cs_n, if1.o_dac_sclk, if1.o_dac_mosi,
            if1.o_sample_ack, if1.o_busy, if1.o_overrun};
  endfunction

  function automatic int getCount(input int id, input int which);
    case (which)
      W_STARTS: return starts[id];
      W_DONES:  return dones[id];
      W_RISES:  return curRises[id];
      default:  return int'(sig(id) & 6'h01);
    endcase
  endfunction

  // Rebuild SPI frames from the pins, sampled mid-cycle on the falling edge
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      monS = sig(id);
      if (prevCs[id] && !monS[5]) begin
        fallAt[id]      = cyc;
        curRises[id]    = 0;
        firstRiseAt[id] = -1;
        shiftCap[id]    = '0;
        ackFall[id]     = monS[2];
        starts[id]      = starts[id] + 1;
      end else if (monS[2]) begin
        strayAck[id] = strayAck[id] + 1;
      end
      if (!monS[5] && !prevSclk[id] && monS[4]) begin
        shiftCap[id] = {shiftCap[id][22:0], monS[3]};
        if (curRises[id] == 0) firstRiseAt[id] = cyc;
        curRises[id] = curRises[id] + 1;
      end
      if (monS[5] && (monS[4] || monS[3])) idleErr[id] = idleErr[id] + 1;
      if (monS[1] !== !monS[5]) busyErr[id] = busyErr[id] + 1;
      if (!prevCs[id] && monS[5]) begin
        monRec.data    = shiftCap[id];
        monRec.rises   = curRises[id];
        monRec.len     = cyc - fallAt[id];
        monRec.riseOff = firstRiseAt[id] - fallAt[id];
        monRec.ack     = ackFall[id];
        monRec.fallCyc = fallAt[id];
        if (id == 0) gotQ0.push_back(monRec);
        else         gotQ1.push_back(monRec);
        dones[id] = dones[id] + 1;
      end
      prevCs[id]   = monS[5];
      prevSclk[id] = monS[4];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one instance's inputs just after a rising edge
  task automatic applyStimulus(input int id, input logic en, input logic [15:0] data);
    @(posedge clk);
    #1;
    if (id == 0) begin
      if0.i_enable = en;
      if0.i_data   = data;
    end else begin
      if1.i_enable = en;
      if1.i_data   = data;
    end
  endtask

  task automatic pushExpected(input int id, input logic [15:0] data);
    if (id == 0) expQ0.push_back({CMD0, data});
    else         expQ1.push_back({CMD1, data});
  endtask

  task automatic waitCount(input int id, input int which, input int target,
                           input int budget, input string tag);
    int n = 0;
    while (getCount(id, which) < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_reached"}, 32'(getCount(id, which) >= target), 32'd1);
  endtask

  // Pop the next captured and expected frame of an instance and compare them
  task automatic checkFrame(input int id, input string tag, output int fallCyc);
    frame_t      g;
    logic [23:0] e;
    int          haveGot;
    int          haveExp;
    fallCyc = 0;
    haveGot = (id == 0) ? gotQ0.size() : gotQ1.size();
    haveExp = (id == 0) ? expQ0.size() : expQ1.size();
    checkOutput({tag, "_frame_seen"}, 32'(haveGot > 0 && haveExp > 0), 32'd1);
    if (haveGot > 0 && haveExp > 0) begin
      g = (id == 0) ? gotQ0.pop_front() : gotQ1.pop_front();
      e = (id == 0) ? expQ0.pop_front() : expQ1.pop_front();
      fallCyc = g.fallCyc;
      checkOutput({tag, "_data"},      32'(g.data),    32'(e));
      checkOutput({tag, "_rises"},     32'(g.rises),   32'd24);
      checkOutput({tag, "_length"},    32'(g.len),     32'(FRAME_LEN));
      checkOutput({tag, "_first_sclk"}, 32'(g.riseOff), 32'(H));
      checkOutput({tag, "_ack_at_cs"}, 32'(g.ack),     32'd1);
    end
  endtask

  // Abort the run if anything above stalls past every cycle budget
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k0;
    int fA;
    int fB;
    int fC;
    int fD;
    frame_t ab;

    rst          = 1'b1;
    if0.i_enable = 1'b1;
    if0.i_data   = 16'h1111;
    if1.i_enable = 1'b1;
    if1.i_data   = 16'h2222;

    $display("[TB] reset behaviour");
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 2; id++) begin
      checkOutput($sformatf("rst%0d_cs_n", id),    32'(sig(id) >> 5 & 6'h01), 32'd1);
      checkOutput($sformatf("rst%0d_sclk", id),    32'(sig(id) >> 4 & 6'h01), 32'd0);
      checkOutput($sformatf("rst%0d_mosi", id),    32'(sig(id) >> 3 & 6'h01), 32'd0);
      checkOutput($sformatf("rst%0d_ack", id),     32'(sig(id) >> 2 & 6'h01), 32'd0);
      checkOutput($sformatf("rst%0d_busy", id),    32'(sig(id) >> 1 & 6'h01), 32'd0);
      checkOutput($sformatf("rst%0d_overrun", id), 32'(sig(id) & 6'h01),      32'd0);
    end
    if0.i_enable = 1'b0;
    if1.i_enable = 1'b0;
    rst          = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    checkOutput("disabled_no_frames0", 32'(starts[0]), 32'd0);
    checkOutput("disabled_no_frames1", 32'(starts[1]), 32'd0);
    checkOutput("disabled_idle_pins0", 32'(idleErr[0]), 32'd0);

    $display("[TB] single frame and periodic stream");
    applyStimulus(0, 1'b1, 16'hA5C3);
    k0 = cyc;
    pushExpected(0, 16'hA5C3);
    waitCount(0, W_STARTS, 1, SD0 + 20, "streamA_start");
    applyStimulus(0, 1'b1, 16'h0001);
    pushExpected(0, 16'h0001);
    waitCount(0, W_STARTS, 2, SD0 + 20, "streamB_start");
    checkOutput("stream_no_overrun", 32'(sig(0) & 6'h01), 32'd0);
    applyStimulus(0, 1'b1, 16'hFFFF);
    pushExpected(0, 16'hFFFF);
    waitCount(0, W_STARTS, 3, SD0 + 20, "streamC_start");
    waitCount(0, W_RISES, 5, 40, "streamC_bit5");
    applyStimulus(0, 1'b0, 16'h1234);
    waitCount(0, W_DONES, 3, FRAME_LEN + 20, "streamC_done");
    checkFrame(0, "frameA", fA);
    checkFrame(0, "frameB", fB);
    checkFrame(0, "frameC", fC);
    checkOutput("tick_latency",  32'(fA - k0), 32'(SD0));
    checkOutput("spacing_AB",    32'(fB - fA), 32'(SD0));
    checkOutput("spacing_BC",    32'(fC - fB), 32'(SD0));
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("disabled_quiet_starts", 32'(starts[0]), 32'd3);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1'b1, 16'hBEEF);
    waitCount(0, W_STARTS, 4, SD0 + 20, "abort_start");
    waitCount(0, W_RISES, 10, 60, "abort_bit10");
    rst = 1'b1;
    #1;
    checkOutput("abort_cs_n_async", 32'(sig(0) >> 5 & 6'h01), 32'd1);
    checkOutput("abort_sclk_async", 32'(sig(0) >> 4 & 6'h01), 32'd0);
    checkOutput("abort_busy_async", 32'(sig(0) >> 1 & 6'h01), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_frame_seen", 32'(gotQ0.size()), 32'd1);
    if (gotQ0.size() > 0) begin
      ab = gotQ0.pop_front();
      checkOutput("abort_rises", 32'(ab.rises), 32'd10);
    end
    if0.i_data = 16'h0F0F;
    rst        = 1'b0;
    k0         = cyc;
    pushExpected(0, 16'h0F0F);
    waitCount(0, W_DONES, 5, SD0 + FRAME_LEN + 20, "after_reset_done");
    checkFrame(0, "frameD", fD);
    checkOutput("after_reset_latency", 32'(fD - k0), 32'(SD0));
    applyStimulus(0, 1'b0, 16'h0000);

    $display("[TB] overrun");
    applyStimulus(1, 1'b1, 16'h1357);
    k0 = cyc;
    pushExpected(1, 16'h1357);
    waitCount(1, W_STARTS, 1, SD1 + 20, "ovr_first_start");
    checkOutput("ovr_clear_before", 32'(sig(1) & 6'h01), 32'd0);
    applyStimulus(1, 1'b1, 16'h2468);
    waitCount(1, W_OVERRUN, 1, SD1 + 20, "ovr_set");
    applyStimulus(1, 1'b1, 16'h9ABC);
    pushExpected(1, 16'h9ABC);
    waitCount(1, W_DONES, 2, SD1 + FRAME_LEN + 40, "ovr_second_done");
    checkFrame(1, "ovr_frame1", fA);
    checkFrame(1, "ovr_frame2", fB);
    checkOutput("ovr_first_latency", 32'(fA - k0), 32'(SD1));
    checkOutput("ovr_spacing",       32'(fB - fA), 32'(2 * SD1));
    checkOutput("ovr_sticky",        32'(sig(1) & 6'h01), 32'd1);
    applyStimulus(1, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("ovr_cleared_by_disable", 32'(sig(1) & 6'h01), 32'd0);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("ovr_no_more_frames", 32'(starts[1]), 32'd2);

    for (int id = 0; id < 2; id++) begin
      checkOutput($sformatf("stray_ack%0d", id),  32'(strayAck[id]), 32'd0);
      checkOutput($sformatf("idle_pins%0d", id),  32'(idleErr[id]),  32'd0);
      checkOutput($sformatf("busy_track%0d", id), 32'(busyErr[id]),  32'd0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
